// File: rtl/ysyx_22041071_axi_r_slave.sv
// AXI4 read-channel responder backed by an internal 64-bit-word memory.
// Accepts one AR request at a time and returns its R beats. FIXED, INCR and
// WRAP bursts are supported. A backdoor write port preloads the memory.
// Optional build macro YSYX_22041071_AXI_R_SLAVE_GAP_EN: when defined, r_valid
// drops for exactly one cycle after every non-last R handshake.
//
// Handshake rule on both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. Once asserted, valid and its payload
// stay unchanged until that transfer. Ready may change freely.
module ysyx_22041071_axi_r_slave #(
  parameter int                ADDR_W     = 64,
  parameter int                DATA_W     = 64,
  parameter int                ID_W       = 4,
  parameter int                DEPTH      = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int                RD_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     axi_ar_valid_i,
  output logic                     axi_ar_ready_o,
  input  logic [ID_W-1:0]          axi_ar_id_i,
  input  logic [ADDR_W-1:0]        axi_ar_addr_i,
  input  logic [7:0]               axi_ar_len_i,
  input  logic [2:0]               axi_ar_size_i,
  input  logic [1:0]               axi_ar_burst_i,
  output logic                     axi_r_valid_o,
  input  logic                     axi_r_ready_i,
  output logic [ID_W-1:0]          axi_r_id_o,
  output logic [DATA_W-1:0]        axi_r_data_o,
  output logic [1:0]               axi_r_resp_o,
  output logic                     axi_r_last_o,
  input  logic                     mem_we_i,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0]        mem_wdata_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + (ADDR_W'(DEPTH) << 3);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_e;

  state_e              state_q, state_d;
  logic [3:0]          lat_q, lat_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                r_valid_q, r_valid_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;
  logic                r_last_q, r_last_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [7:0]          sel_len;
  logic [2:0]          sel_size;
  logic [1:0]          sel_burst;
  logic [ADDR_W-1:0]   incr, wrap_mask, next_addr, beat_addr;
  logic                slv_err, dec_err, beat_last;
  logic [IDX_W-1:0]    beat_idx;
  logic [DATA_W-1:0]   beat_data;
  logic [1:0]          beat_resp;

  assign axi_ar_ready_o = (state_q == S_IDLE);
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_id_o     = id_q;
  assign axi_r_data_o   = r_data_q;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_last_o   = r_last_q;

  // Backdoor write port. The memory has no reset, and a read in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we_i) mem_q[mem_waddr_i] <= mem_wdata_i;
  end

  // Compute the beat that will be loaded into the R registers next.
  // In IDLE the fields come straight from AR, otherwise from the latched request.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_len   = axi_ar_len_i;
      sel_size  = axi_ar_size_i;
      sel_burst = axi_ar_burst_i;
    end else begin
      sel_len   = len_q;
      sel_size  = size_q;
      sel_burst = burst_q;
    end
    incr      = ADDR_W'(1) << sel_size;
    wrap_mask = ((ADDR_W'(sel_len) + ADDR_W'(1)) << sel_size) - ADDR_W'(1);
    case (sel_burst)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: next_addr = addr_q + incr;
    endcase
    case (state_q)
      S_IDLE: begin
        beat_addr = axi_ar_addr_i;
        beat_last = (axi_ar_len_i == 8'd0);
      end
      S_WAIT: begin
        beat_addr = addr_q;
        beat_last = (cnt_q == 8'd0);
      end
      default: begin
        beat_addr = next_addr;
        beat_last = (cnt_q == 8'd1);
      end
    endcase
    // A malformed request fails every beat. This check takes priority over address decode.
    slv_err  = (sel_burst == 2'b11) || (sel_size > 3'd3) ||
               ((sel_burst == 2'b10) && !(sel_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    dec_err  = (beat_addr < BASE_ADDR) || (beat_addr >= END_ADDR);
    beat_idx = IDX_W'((beat_addr - BASE_ADDR) >> 3);
    if (slv_err) begin
      beat_data = '0;
      beat_resp = 2'b10;
    end else if (dec_err) begin
      beat_data = '0;
      beat_resp = 2'b11;
    end else begin
      beat_data = mem_q[beat_idx];
      beat_resp = 2'b00;
    end
  end

  // State and R output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  // Next state: accept AR, count the latency, then stream the beats.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    id_d      = id_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    case (state_q)
      S_IDLE: begin
        if (axi_ar_valid_i) begin
          id_d    = axi_ar_id_i;
          addr_d  = axi_ar_addr_i;
          len_d   = axi_ar_len_i;
          size_d  = axi_ar_size_i;
          burst_d = axi_ar_burst_i;
          cnt_d   = axi_ar_len_i;
          lat_d   = 4'(RD_LATENCY);
          if (RD_LATENCY == 0) begin
            state_d   = S_BEAT;
            r_valid_d = 1'b1;
            r_data_d  = beat_data;
            r_resp_d  = beat_resp;
            r_last_d  = beat_last;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The counter holds the number of idle cycles left, so leave as it reaches zero.
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d   = S_BEAT;
          r_valid_d = 1'b1;
          r_data_d  = beat_data;
          r_resp_d  = beat_resp;
          r_last_d  = beat_last;
        end
      end
      S_BEAT: begin
        if (r_valid_q && axi_r_ready_i) begin
          if (cnt_q == 8'd0) begin
            state_d   = S_IDLE;
            r_valid_d = 1'b0;
            r_last_d  = 1'b0;
          end else begin
            cnt_d     = cnt_q - 8'd1;
            addr_d    = next_addr;
            r_valid_d = 1'b1;
            r_data_d  = beat_data;
            r_resp_d  = beat_resp;
            r_last_d  = beat_last;
`ifdef YSYX_22041071_AXI_R_SLAVE_GAP_EN
            r_valid_d = 1'b0;
`endif
          end
        end
`ifdef YSYX_22041071_AXI_R_SLAVE_GAP_EN
        else if (!r_valid_q) begin
          r_valid_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_r_slave.sv
// Bench for ysyx_22041071_axi_r_slave: directed cases plus randomized bursts,
// compared against a burst-level reference model and an expected-beat queue.
`timescale 1ns/1ps
module tb_ysyx_22041071_axi_r_slave;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int ID_W       = 4;
  localparam int DEPTH      = 1024;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int RD_LATENCY = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] TOP  = BASE + 64'(8 * DEPTH);
`ifdef YSYX_22041071_AXI_R_SLAVE_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              axi_ar_valid_i, axi_ar_ready_o;
  logic [ID_W-1:0]   axi_ar_id_i;
  logic [ADDR_W-1:0] axi_ar_addr_i;
  logic [7:0]        axi_ar_len_i;
  logic [2:0]        axi_ar_size_i;
  logic [1:0]        axi_ar_burst_i;
  logic              axi_r_valid_o, axi_r_ready_i;
  logic [ID_W-1:0]   axi_r_id_o;
  logic [DATA_W-1:0] axi_r_data_o;
  logic [1:0]        axi_r_resp_o;
  logic              axi_r_last_o;
  logic              mem_we_i;
  logic [IDX_W-1:0]  mem_waddr_i;
  logic [DATA_W-1:0] mem_wdata_i;

  ysyx_22041071_axi_r_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .axi_ar_valid_i(axi_ar_valid_i), .axi_ar_ready_o(axi_ar_ready_o),
    .axi_ar_id_i(axi_ar_id_i), .axi_ar_addr_i(axi_ar_addr_i),
    .axi_ar_len_i(axi_ar_len_i), .axi_ar_size_i(axi_ar_size_i),
    .axi_ar_burst_i(axi_ar_burst_i),
    .axi_r_valid_o(axi_r_valid_o), .axi_r_ready_i(axi_r_ready_i),
    .axi_r_id_o(axi_r_id_o), .axi_r_data_o(axi_r_data_o),
    .axi_r_resp_o(axi_r_resp_o), .axi_r_last_o(axi_r_last_o),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i)
  );

  // ---------------- scoreboard ----------------
  logic [63:0]     ref_mem [DEPTH];
  logic [66:0]     exp_q[$];          // {last, resp, data}
  logic [ID_W-1:0] cur_id;
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: expand one request into its expected beats.
  task automatic model_burst(input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] incr, bound, start, a, data;
    logic [1:0]  resp;
    bit slv, dec;
    incr  = 64'd1 << size;
    bound = (64'(len) + 64'd1) * incr;
    start = addr - (addr % bound);
    slv   = (burst == 2'b11) || (size > 3'd3) ||
            (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'b00:   a = addr;
        2'b10:   a = start + ((addr - start + 64'(i) * incr) % bound);
        default: a = addr + 64'(i) * incr;
      endcase
      dec = (a < BASE) || (a >= TOP);
      if (slv) begin
        data = '0; resp = 2'b10;
      end else if (dec) begin
        data = '0; resp = 2'b11;
      end else begin
        data = ref_mem[int'((a - BASE) >> 3)]; resp = 2'b00;
      end
      exp_q.push_back({(i == int'(len)), resp, data});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bd_write(input int idx, input logic [63:0] d);
    mem_we_i = 1'b1; mem_waddr_i = IDX_W'(idx); mem_wdata_i = d;
    @(negedge clk);
    mem_we_i = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Issue an AR. Starts and ends at a falling edge, and ends just after the handshake edge.
  task automatic ar_send(input logic [ID_W-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit bd_en, input int bd_idx, input logic [63:0] bd_data);
    int n;
    model_burst(addr, len, size, burst);
    cur_id = id;
    axi_ar_valid_i = 1'b1; axi_ar_id_i = id; axi_ar_addr_i = addr;
    axi_ar_len_i = len; axi_ar_size_i = size; axi_ar_burst_i = burst;
    n = 0;
    while (!axi_ar_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready", 64'(axi_ar_ready_o), 64'd1);
    if (bd_en && RD_LATENCY == 0) begin
      mem_we_i = 1'b1; mem_waddr_i = IDX_W'(bd_idx); mem_wdata_i = bd_data;
    end
    @(negedge clk);
    axi_ar_valid_i = 1'b0;
    axi_ar_addr_i  = 64'($urandom);
  endtask

  // Collect R beats. mode 0: always ready, 1: stall beat index 1 for two cycles, 2: random ready.
  // When abort_at matches a beat index, reset is pulsed while that beat is shown.
  task automatic collect(input int mode, input int abort_at, input bit bd_en,
                         input int bd_idx, input logic [63:0] bd_data);
    int idle, guard, beat, stall;
    bit rdy;
    logic [66:0] e;
    idle = 0;
    while (idle < 64) begin
      if (axi_r_valid_o) break;
      mem_we_i = bd_en && (idle == RD_LATENCY - 1);
      mem_waddr_i = IDX_W'(bd_idx); mem_wdata_i = bd_data;
      idle++;
      @(negedge clk);
    end
    mem_we_i = 1'b0;
    if (bd_en) ref_mem[bd_idx] = bd_data;
    chk("latency", 64'(idle), 64'(RD_LATENCY));
    chk("ar_busy", 64'(axi_ar_ready_o), 64'd0);
    beat = 0; stall = 0; guard = 0; rdy = 1'b1;
    while (exp_q.size() > 0 && guard < 4000) begin
      e = exp_q[0];
      chk("rvalid", 64'(axi_r_valid_o), 64'd1);
      chk("rdata", axi_r_data_o, e[63:0]);
      chk("rresp", 64'(axi_r_resp_o), 64'(e[65:64]));
      chk("rlast", 64'(axi_r_last_o), 64'(e[66]));
      chk("rid", 64'(axi_r_id_o), 64'(cur_id));
      if (beat == abort_at) begin
        #2 reset_n = 1'b0;
        #1 chk("rst_rvalid", 64'(axi_r_valid_o), 64'd0);
        chk("rst_arready", 64'(axi_ar_ready_o), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        axi_r_ready_i = 1'b0;
        exp_q.delete();
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: begin
          rdy = !(beat == 1 && stall < 2);
          if (!rdy) stall++;
        end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      axi_r_ready_i = rdy;
      @(negedge clk);
      guard++;
      if (rdy) begin
        void'(exp_q.pop_front());
        beat++;
        if (exp_q.size() > 0) begin
          chk("after_hs_valid", 64'(axi_r_valid_o), 64'(!GAP));
          if (GAP) @(negedge clk);
        end
      end
    end
    chk("drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("end_rvalid", 64'(axi_r_valid_o), 64'd0);
    chk("end_arready", 64'(axi_ar_ready_o), 64'd1);
    axi_r_ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int sel;
    reset_n = 1'b1;
    axi_ar_valid_i = 1'b0; axi_ar_id_i = '0; axi_ar_addr_i = '0; axi_ar_len_i = '0;
    axi_ar_size_i = '0; axi_ar_burst_i = '0; axi_r_ready_i = 1'b0;
    mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_arready", 64'(axi_ar_ready_o), 64'd1);
    chk("rst_rvalid", 64'(axi_r_valid_o), 64'd0);
    chk("rst_rlast", 64'(axi_r_last_o), 64'd0);
    chk("rst_rid", 64'(axi_r_id_o), 64'd0);
    chk("rst_rdata", axi_r_data_o, 64'd0);
    chk("rst_rresp", 64'(axi_r_resp_o), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) bd_write(i, {$urandom, $urandom});
    bd_write(0, 64'h1111);
    bd_write(1, 64'h2222);

    // single beat, latency and id
    ar_send(4'd5, BASE, 8'd0, 3'd3, 2'b01, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);

    // INCR with a stalled second beat
    bd_write(1, 64'hAAAA_0001); bd_write(2, 64'hBBBB_0002);
    bd_write(3, 64'hCCCC_0003); bd_write(4, 64'hDDDD_0004);
    ar_send(4'd3, BASE + 64'd8, 8'd3, 3'd3, 2'b01, 1'b0, 0, '0);
    collect(1, -1, 1'b0, 0, '0);

    // WRAP from the middle of a 32-byte window
    ar_send(4'd7, BASE + 64'h10, 8'd3, 3'd3, 2'b10, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);

    // out of range, reserved burst, invalid wrap length
    ar_send(4'd2, TOP, 8'd1, 3'd3, 2'b01, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);
    ar_send(4'd9, BASE, 8'd0, 3'd3, 2'b11, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);
    ar_send(4'd8, BASE, 8'd2, 3'd3, 2'b10, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);

    // backdoor write landing on the beat-load edge: old data, then new data
    ar_send(4'd4, BASE + 64'd56, 8'd0, 3'd3, 2'b01, 1'b1, 7, 64'hDEAD_BEEF_0000_0007);
    collect(0, -1, 1'b1, 7, 64'hDEAD_BEEF_0000_0007);
    ar_send(4'd4, BASE + 64'd56, 8'd0, 3'd3, 2'b01, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);

    // reset during beat 2 of an 8-beat burst, then a fresh read
    ar_send(4'd6, BASE, 8'd7, 3'd3, 2'b01, 1'b0, 0, '0);
    collect(0, 1, 1'b0, 0, '0);
    ar_send(4'd6, BASE + 64'd16, 8'd0, 3'd3, 2'b01, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);

    // three beats with ready held high: back-to-back, or gapped when enabled
    ar_send(4'd1, BASE + 64'd32, 8'd2, 3'd3, 2'b01, 1'b0, 0, '0);
    collect(0, -1, 1'b0, 0, '0);

    // randomized bursts
    repeat (60) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = BASE - 64'(8 * $urandom_range(1, 4));
      else if (sel == 1) addr = TOP - 64'(8 * $urandom_range(0, 3));
      else               addr = BASE + 64'($urandom_range(0, 8 * DEPTH - 1));
      burst = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      size  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if (burst == 2'b10 && $urandom_range(0, 7) != 0) begin
        sel = $urandom_range(0, 3);
        len = (sel == 0) ? 8'd1 : (sel == 1) ? 8'd3 : (sel == 2) ? 8'd7 : 8'd15;
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      ar_send(4'($urandom_range(0, 15)), addr, len, size, burst, 1'b0, 0, '0);
      collect(2, -1, 1'b0, 0, '0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
